fetch_queue: RTL
================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning PC/address width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, meaning number of entries; legal values are powers of two, 2 to 16.
REQ-003 SHALL have parameter PTR_W, default $clog2(DEPTH), meaning read/write pointer width.
REQ-004 SHALL have ports: clk  input  1  rising-edge clock (sole clock domain).
REQ-005 SHALL have ports: rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have ports: flush_i  input  1  discard all entries (redirect or branch taken).
REQ-007 SHALL have ports: push_valid_i  input  1  fetch side offers an entry.
REQ-008 SHALL have ports: push_ready_o  output  1  queue accepts an entry.
REQ-009 SHALL have ports: push_pc_i  input  XLEN  PC of the fetched instruction.
REQ-010 SHALL have ports: push_instr_i  input  32  fetched instruction word.
REQ-011 SHALL have ports: pop_valid_o  output  1  head entry available to decode.
REQ-012 SHALL have ports: pop_ready_i  input  1  decode consumes the head (low = decode stall).
REQ-013 SHALL have ports: pop_pc_o  output  XLEN  head PC.
REQ-014 SHALL have ports: pop_pc_plus_4_o  output  XLEN  head PC + 4, modulo 2^XLEN.
REQ-015 SHALL have ports: pop_instr_o  output  32  head instruction.
REQ-016 SHALL have ports: count_o  output  PTR_W+1  current occupancy, 0..DEPTH.

Function
REQ-017 SHALL perform a push when push_valid_i & push_ready_o & !flush_i; the entry is written at wr_ptr, and wr_ptr advances modulo DEPTH.
REQ-018 SHALL perform a pop when pop_valid_o & pop_ready_i & !flush_i; rd_ptr advances modulo DEPTH.
REQ-019 SHALL drive push_ready_o = (count < DEPTH) & !flush_i; push_ready_o SHALL NOT depend combinationally on pop_ready_i.
REQ-020 SHALL drive pop_valid_o = (count != 0) & !flush_i, except where REQ-032 applies.
REQ-021 SHALL update count as follows on each edge: push only +1; pop only -1; push and pop together unchanged; neither unchanged.
REQ-022 SHALL have a latency of one cycle without bypass: an entry pushed at edge N is visible at the pop side after edge N.
REQ-023 SHALL preserve strict FIFO order, including across pointer wrap-around.
REQ-024 SHALL refuse pushes when full (count = DEPTH); a simultaneous pop still proceeds, and count becomes DEPTH-1.
REQ-025 SHALL drive pop_pc_o = 0, pop_pc_plus_4_o = 4 and pop_instr_o = 0x00000013 (NOP) when pop_valid_o = 0.
REQ-026 SHALL, on flush_i, at the next edge set count=0, wr_ptr=0 and rd_ptr=0, ignore any push and pop in that cycle, and hold pop_valid_o and push_ready_o low combinationally during the flush cycle.
REQ-027 SHALL resume normal operation, with pushes accepted, in the cycle after flush_i deasserts.
REQ-028 SHALL leave entry storage unreset and unflushed; only pointers and count are cleared.

Reset
REQ-029 SHALL, while rst=1, asynchronously force count=0, wr_ptr=0 and rd_ptr=0; the outputs are then pop_valid_o=0, push_ready_o=0, count_o=0 and the NOP outputs of REQ-025.
REQ-030 SHALL release reset synchronously to clk; push_ready_o=1 in the first cycle after release.
REQ-031 SHALL abandon all contents when reset asserts mid-operation, with no partial pointer update.

Configuration
REQ-032 SHALL, with FETCH_QUEUE_BYPASS_EN defined, when count=0, !flush_i and push_valid_i=1, drive pop_valid_o=1 combinationally with the push_* data (pop_pc_plus_4_o = push_pc_i+4); if pop_ready_i=1, the entry is consumed and not stored, and count stays 0.
REQ-033 SHALL, without FETCH_QUEUE_BYPASS_EN, have no combinational path from any push_* input to any pop_* output; empty-queue latency is one cycle per REQ-022.

Verification
REQ-034 SHALL cover fill/drain: push PCs 0x0,0x4,0x8,0xC with pop_ready_i=0 -> count_o=4 and push_ready_o=0; then pop_ready_i=1 -> pops 0x0,0x4,0x8,0xC in order with pop_pc_plus_4_o 0x4..0x10.
REQ-035 SHALL cover wrap-around: 10 continuous push+pop of PCs 0x100+4k with DEPTH=4 -> output order is exact and count_o stays constant at 1.
REQ-036 SHALL cover full with simultaneous pop: count=4, push_valid_i=1, pop_ready_i=1 -> one pop, no push, count_o=3, and the next cycle the push is accepted.
REQ-037 SHALL cover flush: count=3, flush_i=1 with push_valid_i=1 -> pop_valid_o=0 in that cycle and count_o=0 next cycle; the next push of PC 0x200 is popped first.
REQ-038 SHALL cover reset mid-operation: rst pulses while count=2 -> count_o=0 and pop_instr_o=0x00000013 immediately, without waiting for a clock edge.
REQ-039 SHALL cover bypass: empty queue, push PC 0x40, instr 0x00500093, pop_ready_i=1 -> with the macro, pop_valid_o=1 in the same cycle and count_o stays 0; without the macro, pop_valid_o=1 one cycle later.

Source files
------------

// File: rtl/fetch_queue.sv
// fetch_queue: fetch-to-decode instruction FIFO with flush and async reset.
// Define FETCH_QUEUE_BYPASS_EN to let a push into an empty queue reach decode in the same cycle.
module fetch_queue #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush_i,
   input  logic             push_valid_i,
   output logic             push_ready_o,
   input  logic [XLEN-1:0]  push_pc_i,
   input  logic [31:0]      push_instr_i,
   output logic             pop_valid_o,
   input  logic             pop_ready_i,
   output logic [XLEN-1:0]  pop_pc_o,
   output logic [XLEN-1:0]  pop_pc_plus_4_o,
   output logic [31:0]      pop_instr_o,
   output logic [PTR_W:0]   count_o
);
   localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);
   localparam logic [31:0] NOP = 32'h0000_0013;
   logic [XLEN-1:0] pc_mem [DEPTH];
   logic [31:0] instr_mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0] count_q, count_d;
   logic empty, bypass, store, pop_mem;
   assign empty = count_q == '0;
`ifdef FETCH_QUEUE_BYPASS_EN
   assign bypass = empty & push_valid_i & !flush_i & !rst;
`else
   assign bypass = 1'b0;
`endif
   assign push_ready_o = !rst & !flush_i & (count_q != FULL);
   assign pop_valid_o = !flush_i & (!empty | bypass);
   // a bypassed entry taken by decode in the same cycle never touches storage
   assign store = push_valid_i & push_ready_o & !(bypass & pop_ready_i);
   assign pop_mem = pop_valid_o & pop_ready_i & !empty;
   always_comb begin
      wr_ptr_d = flush_i ? '0 : wr_ptr_q + PTR_W'(store);
      rd_ptr_d = flush_i ? '0 : rd_ptr_q + PTR_W'(pop_mem);
      count_d = flush_i ? '0 : count_q + (PTR_W+1)'(store) - (PTR_W+1)'(pop_mem);
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q <= count_d;
      end
   end
   always_ff @(posedge clk) begin
      if (store) begin
         pc_mem[wr_ptr_q] <= push_pc_i;
         instr_mem[wr_ptr_q] <= push_instr_i;
      end
   end
   always_comb begin
      pop_pc_o = !pop_valid_o ? '0 : bypass ? push_pc_i : pc_mem[rd_ptr_q];
      pop_instr_o = !pop_valid_o ? NOP : bypass ? push_instr_i : instr_mem[rd_ptr_q];
      pop_pc_plus_4_o = pop_pc_o + XLEN'(4);
   end
   assign count_o = count_q;
endmodule
